// File: rtl/pipelined_functional_unit.sv
// Fully pipelined ADD/SUB/MUL/SLT unit between a reservation station and the CDB arbiter.
// Results are formed at issue and carried through LATENCY stages; the last stage drives the bus.
module pipelined_functional_unit #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TAG_W   = 3,
   parameter int unsigned LATENCY = 4,
   parameter int unsigned MUL_EN  = 1,
   localparam int unsigned CNT_W  = $clog2(LATENCY + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             bus_valid,
   input  logic             bus_grant,
   output logic [TAG_W-1:0] bus_tag,
   output logic [WIDTH-1:0] bus_value,
   output logic [CNT_W-1:0] busy_count
);

   typedef enum logic [1:0] {
      OpAdd = 2'b00,
      OpSub = 2'b01,
      OpMul = 2'b10,
      OpSlt = 2'b11
   } op_e;

   localparam int unsigned Last = LATENCY - 1;

   logic [LATENCY-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q [LATENCY];
   logic [TAG_W-1:0]   tag_d [LATENCY];
   logic [WIDTH-1:0]   res_q [LATENCY];
   logic [WIDTH-1:0]   res_d [LATENCY];
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic             advance;
   logic             accept;
   op_e              op;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] prod;
   logic             lt;
   logic [WIDTH-1:0] alu_res;

   // The whole pipe moves together; a held output freezes every stage behind it.
   assign advance  = !valid_q[Last] || bus_grant;
   assign in_ready = advance && !flush && !rst;
   assign accept   = in_valid && in_ready;

   assign op   = op_e'(in_op);
   assign sum  = in_a + in_b;
   assign diff = in_a - in_b;
   assign lt   = $signed(in_a) < $signed(in_b);

   generate
      if (MUL_EN != 0) begin : g_mul
         assign prod = in_a * in_b;
      end else begin : g_no_mul
         assign prod = '0;
      end
   endgenerate

   always_comb begin
      alu_res = '0;
      case (op)
         OpAdd:   alu_res = sum;
         OpSub:   alu_res = diff;
         OpMul:   alu_res = prod;
         OpSlt:   alu_res = {{(WIDTH - 1){1'b0}}, lt};
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      res_d   = res_q;
      if (flush) begin
         // Data is left stale; only the valid bits matter after a kill.
         valid_d = '0;
      end else if (advance) begin
         for (int i = 1; i < int'(LATENCY); i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
            res_d[i]   = res_q[i-1];
         end
         valid_d[0] = accept;
         tag_d[0]   = in_tag;
         res_d[0]   = alu_res;
      end
      cnt_d = '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
         cnt_d = cnt_d + CNT_W'(valid_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < int'(LATENCY); i++) begin
            tag_q[i] <= '0;
            res_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
         res_q   <= res_d;
      end
   end

   assign bus_valid  = valid_q[Last] && !flush;
   assign bus_tag    = tag_q[Last];
   assign bus_value  = res_q[Last];
   assign busy_count = cnt_q;

endmodule

// File: tb/tb_pipelined_functional_unit.sv
// Scoreboard bench: issue pushes expected {tag, value}; monitors pop on each granted result.
module tb_pipelined_functional_unit;

   localparam int Lat = 4;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic        in_valid, in_ready, bus_valid, bus_grant;
   logic [1:0]  in_op;
   logic [31:0] in_a, in_b, bus_value;
   logic [2:0]  in_tag, bus_tag, busy_count;

   logic        nm_in_valid, nm_in_ready, nm_bus_valid, nm_bus_grant;
   logic [1:0]  nm_in_op;
   logic [31:0] nm_in_a, nm_in_b, nm_bus_value;
   logic [2:0]  nm_in_tag, nm_bus_tag, nm_busy_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  tag;
      logic [31:0] value;
   } exp_t;

   exp_t sb[$];
   exp_t sb_nm[$];

   always #5 clk = ~clk;

   pipelined_functional_unit #(
      .WIDTH(32), .TAG_W(3), .LATENCY(Lat), .MUL_EN(1)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .bus_valid(bus_valid), .bus_grant(bus_grant), .bus_tag(bus_tag),
      .bus_value(bus_value), .busy_count(busy_count)
   );

   pipelined_functional_unit #(
      .WIDTH(32), .TAG_W(3), .LATENCY(Lat), .MUL_EN(0)
   ) dut_nm (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(nm_in_valid), .in_ready(nm_in_ready), .in_op(nm_in_op),
      .in_a(nm_in_a), .in_b(nm_in_b), .in_tag(nm_in_tag),
      .bus_valid(nm_bus_valid), .bus_grant(nm_bus_grant), .bus_tag(nm_bus_tag),
      .bus_value(nm_bus_value), .busy_count(nm_busy_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] tag, input logic [31:0] exp);
      exp_t e;
      int   n;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
      #1;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      check($sformatf("issue_ready_tag%0d", tag), {31'b0, in_ready}, 32'd1);
      if (in_ready === 1'b1) begin
         e.tag   = tag;
         e.value = exp;
         sb.push_back(e);
      end
      step();
      in_valid = 1'b0;
   endtask

   // Called right after the accepting edge; bus_valid must rise after exactly Lat-1 more edges.
   task automatic latency_check(input string name);
      for (int i = 0; i <= Lat; i++) begin
         check($sformatf("%s_%0d", name, i), {31'b0, bus_valid}, {31'b0, (i == Lat - 1)});
         step();
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus_valid === 1'b1 && bus_grant === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: tag %0d value 0x%08h with none expected",
                     bus_tag, bus_value);
         end else begin
            e = sb.pop_front();
            check("result_tag", {29'b0, bus_tag}, {29'b0, e.tag});
            check("result_value", bus_value, e.value);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (nm_bus_valid === 1'b1 && nm_bus_grant === 1'b1) begin
         if (sb_nm.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL nm_unexpected_result: tag %0d value 0x%08h with none expected",
                     nm_bus_tag, nm_bus_value);
         end else begin
            e = sb_nm.pop_front();
            check("nm_result_tag", {29'b0, nm_bus_tag}, {29'b0, e.tag});
            check("nm_result_value", nm_bus_value, e.value);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      exp_t e;
      rst = 1'b1; flush = 1'b0; bus_grant = 1'b1;
      in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
      nm_in_valid = 1'b0; nm_in_op = 2'b00; nm_in_a = '0; nm_in_b = '0; nm_in_tag = '0;
      nm_bus_grant = 1'b1;

      // Reset for two edges
      step();
      #1;
      check("ready_during_reset", {31'b0, in_ready}, 32'd0);
      step();
      rst = 1'b0;
      #1;
      check("reset_bus_valid", {31'b0, bus_valid}, 32'd0);
      check("reset_bus_value", bus_value, 32'd0);
      check("reset_bus_tag", {29'b0, bus_tag}, 32'd0);
      check("reset_busy", {29'b0, busy_count}, 32'd0);
      check("reset_ready", {31'b0, in_ready}, 32'd1);

      // Single ADD with latency measurement
      issue(2'b00, 32'd5, 32'd7, 3'd3, 32'd12);
      check("busy_after_accept", {29'b0, busy_count}, 32'd1);
      latency_check("add_latency");

      // Back-to-back, grant held high
      issue(2'b00, 32'd1, 32'd2, 3'd0, 32'd3);
      issue(2'b01, 32'd3, 32'd5, 3'd1, 32'hFFFF_FFFE);
      issue(2'b10, 32'd6, 32'd7, 3'd2, 32'd42);
      issue(2'b11, 32'hFFFF_FFFF, 32'd1, 3'd3, 32'd1);
      repeat (6) step();

      // Stall: fill with grant low, then hold for five cycles
      bus_grant = 1'b0;
      issue(2'b00, 32'd10, 32'd20, 3'd4, 32'd30);
      issue(2'b01, 32'd100, 32'd1, 3'd5, 32'd99);
      issue(2'b10, 32'd3, 32'd5, 3'd6, 32'd15);
      issue(2'b11, 32'd5, 32'hFFFF_FFFD, 3'd7, 32'd0);
      in_valid = 1'b1; in_op = 2'b00; in_a = 32'hFFFF_FFFF; in_b = 32'd1; in_tag = 3'd0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_ready", {31'b0, in_ready}, 32'd0);
         check("stall_busy", {29'b0, busy_count}, 32'd4);
         check("stall_bus_valid", {31'b0, bus_valid}, 32'd1);
         check("stall_bus_tag", {29'b0, bus_tag}, 32'd4);
         check("stall_bus_value", bus_value, 32'd30);
         step();
      end
      bus_grant = 1'b1;
      // Wrap: accepted on the same edge the head retires
      issue(2'b00, 32'hFFFF_FFFF, 32'd1, 3'd0, 32'd0);
      repeat (8) step();
      check("stall_drained", sb.size(), 32'd0);

      // Flush with three in flight
      issue(2'b00, 32'd1, 32'd1, 3'd1, 32'd2);
      issue(2'b00, 32'd2, 32'd2, 3'd2, 32'd4);
      issue(2'b00, 32'd3, 32'd3, 3'd3, 32'd6);
      flush = 1'b1;
      sb.delete();
      #1;
      check("flush_ready", {31'b0, in_ready}, 32'd0);
      step();
      flush = 1'b0;
      #1;
      check("post_flush_busy", {29'b0, busy_count}, 32'd0);
      check("post_flush_ready", {31'b0, in_ready}, 32'd1);
      check("post_flush_valid", {31'b0, bus_valid}, 32'd0);
      issue(2'b10, 32'h0001_0000, 32'h0001_0000, 3'd5, 32'd0);
      latency_check("flush_latency");
      repeat (4) step();

      // MUL disabled instance
      nm_in_valid = 1'b1; nm_in_op = 2'b10; nm_in_a = 32'd6; nm_in_b = 32'd7; nm_in_tag = 3'd6;
      #1;
      check("nm_ready", {31'b0, nm_in_ready}, 32'd1);
      e.tag   = 3'd6;
      e.value = 32'd0;
      sb_nm.push_back(e);
      step();
      nm_in_valid = 1'b0;
      repeat (6) step();

      check("sb_empty", sb.size(), 32'd0);
      check("sb_nm_empty", sb_nm.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_functional_unit.md
Name: pipelined_functional_unit

Overview:
- Parametrised, fully pipelined successor to the single-shot add/multiply unit. One instruction per cycle enters from a reservation station; each result is broadcast on the common data bus (CDB) with its ROB tag.
- Adds an op select, a configurable latency, CDB grant back-pressure, synchronous reset and a single-cycle flush that kills all in-flight work.
- Sits between reservation stations and the CDB arbiter.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- TAG_W, 3, ROB tag width.
- LATENCY, 4, pipeline depth in cycles from accept to first bus_valid (>=1).
- MUL_EN, 1, 1 enables OP_MUL; 0 makes OP_MUL produce 0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous kill of every in-flight instruction (mispredict).
- in_valid  in  1  reservation station offers an instruction.
- in_ready  out  1  unit accepts this cycle.
- in_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 SLT (signed a<b).
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_tag  in  TAG_W  destination ROB tag.
- bus_valid  out  1  result presented on the CDB.
- bus_grant  in  1  arbiter accepts the result this cycle.
- bus_tag  out  TAG_W  tag of the presented result.
- bus_value  out  WIDTH  presented result.
- busy_count  out  $clog2(LATENCY+1)  number of valid entries in flight.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Pipeline structure:
  - LATENCY stages, each holding {valid, tag, op, a, b} or a partial result.
  - The result is computed combinationally at stage 0 and shifted through, or retimed. Either is acceptable if externally identical.
  - The last stage is the output register.
- Advance rule:
  - advance = !out_valid || bus_grant.
  - On advance, every stage shifts one position. Empty stages shift as bubbles.
  - When advance=0 the whole pipeline holds. There is no bubble collapse.
- Input handshake:
  - in_ready = advance && !flush && !rst.
  - The instruction is accepted at the rising edge where in_valid && in_ready.
  - When not accepted on an advance, stage 0 loads a bubble.
- Latency:
  - An instruction accepted at edge k, with no stalls, drives bus_valid=1 during the cycle after edge k+LATENCY-1.
  - Each cycle of advance=0 adds one cycle.
  - Throughput is 1 per cycle when bus_grant is held high.
- Output handshake:
  - bus_valid = out_valid && !flush.
  - bus_tag and bus_value are stable while bus_valid=1 and bus_grant=0.
  - Consumption happens at the edge where bus_valid && bus_grant.
  - bus_grant while bus_valid=0 is ignored.
- Arithmetic (all results modulo 2^WIDTH, operands treated as unsigned except SLT):
  - ADD = a+b, with carry discarded.
  - SUB = a-b, two's complement.
  - MUL = low WIDTH bits of a*b.
  - SLT = 1 if signed(a)<signed(b), else 0.
  - MUL_EN=0 with in_op=10 gives a result of 0. The tag is still broadcast.
- Flush:
  - At an edge with flush=1, all valid bits clear. Data registers may keep stale values.
  - Nothing is accepted that cycle.
  - A result granted in the flush cycle is not counted, because bus_valid is gated low.
  - The next cycle the unit is empty and in_ready=1.
- Reset:
  - Same effect as flush. In addition, bus_tag=0, bus_value=0 and busy_count=0.
  - rst has priority over flush and in_valid.
  - After reset: in_ready=1, bus_valid=0.
  - Reset mid-stall discards the held result.
- busy_count equals the popcount of stage valid bits, registered.
  - Full pipeline: busy_count=LATENCY.
  - Full and stalled: busy_count=LATENCY and in_ready=0.
- Simultaneous accept and grant on a full pipeline is legal: the output retires and the new entry enters stage 0 in the same edge.

Test Plan:
- Reset, LATENCY=4: rst for 2 cycles -> bus_valid=0, bus_value=0, busy_count=0, in_ready=1.
- Single ADD: accept a=5, b=7, tag=3, bus_grant=1 -> bus_valid high exactly 4 cycles after accept, tag 3, value 12, for one cycle.
- Back-to-back with grant held: ADD 1+2 (tag 0), SUB 3-5 (tag 1), MUL 6*7 (tag 2), SLT -1<1 (tag 3) on consecutive cycles -> consecutive results 3, 0xFFFFFFFE, 42, 1 with matching tags.
- Stall:
  - Setup: hold bus_grant=0 once the first result appears; keep in_valid=1.
  - While filling: in_ready stays 1 until the pipeline is full.
  - Once full: in_ready=0, busy_count=4, and bus_value/bus_tag are unchanged over 5 cycles.
  - After releasing grant: results drain in order with no loss or duplication.
- Flush: 3 instructions in flight, pulse flush one cycle -> no bus_valid afterwards, busy_count=0 the next cycle, and the next accepted instruction completes in 4 cycles.
- Wrap and disable:
  - 0xFFFFFFFF+1 -> 0.
  - 0x10000*0x10000 -> 0.
  - With MUL_EN=0, MUL 6*7 -> value 0 with its tag broadcast.
